// File: rtl/eltwise_arbiter_pkg.sv
// Shared NPU definitions for the element-wise arbiter: the operand width,
// the opcode encodings and the arbiter FSM state encodings.
package eltwise_arbiter_pkg;

    localparam int NPU_DATA_WIDTH = 16;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MUL  = 3'd2,
        OP_DIV  = 3'd3,
        OP_AND  = 3'd4,
        OP_OR   = 3'd5,
        OP_XOR  = 3'd6,
        OP_NOTA = 3'd7
    } eltwise_op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RESPOND = 3'd3,
        ST_HALT    = 3'd4
    } arb_state_e;

endpackage

// File: rtl/eltwise_arbiter_rr_priority_select.sv
// Combinational round-robin pick: the first set request bit searching
// upward from the requester after last_grant, wrapping around.
module rr_priority_select #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    always_comb begin
        int              cand;
        logic [IDX_W-1:0] cidx;
        cand      = 0;
        cidx      = '0;
        grant_oh  = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        // Offset NUM_REQ comes back to last_grant itself, so it has lowest priority.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_grant) + k) % NUM_REQ;
            cidx = IDX_W'(cand);
            if (!grant_any && req[cidx]) begin
                grant_any       = 1'b1;
                grant_oh[cidx]  = 1'b1;
                grant_idx       = cidx;
            end
        end
    end

endmodule

// File: rtl/eltwise_arbiter.sv
// Shares one element-wise unit among NUM_REQ requesters, one op in flight,
// with round-robin grant, a per-op timeout and a sticky fault that halts the arbiter.
module eltwise_arbiter
    import eltwise_arbiter_pkg::*;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int DATA_WIDTH     = NPU_DATA_WIDTH,
    parameter  int TIMEOUT_CYCLES = 256,
    localparam int IDX_W          = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op_b,
    input  logic [NUM_REQ*3-1:0]          req_op_type,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_err,
    output logic [DATA_WIDTH-1:0]         eu_operand_a,
    output logic [DATA_WIDTH-1:0]         eu_operand_b,
    output logic [2:0]                    eu_op_type,
    output logic                          eu_valid,
    input  logic                          eu_ready,
    input  logic [DATA_WIDTH-1:0]         eu_data,
    input  logic                          eu_valid_out,
    output logic                          eu_ready_out,
    output logic                          busy,
    output logic [IDX_W-1:0]              grant_id,
    output logic                          fault
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    arb_state_e            state_q, state_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic [IDX_W-1:0]      last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
    logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
    eltwise_op_e           op_type_q, op_type_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  fault_q, fault_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0] op_a_arr    [NUM_REQ];
    logic [DATA_WIDTH-1:0] op_b_arr    [NUM_REQ];
    logic [2:0]            op_type_arr [NUM_REQ];

    logic [NUM_REQ-1:0]    win_oh;
    logic [IDX_W-1:0]      win_idx;
    logic                  win_any;
    logic                  timeout_hit;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign op_a_arr[i]    = req_op_a[i*DATA_WIDTH +: DATA_WIDTH];
        assign op_b_arr[i]    = req_op_b[i*DATA_WIDTH +: DATA_WIDTH];
        assign op_type_arr[i] = req_op_type[i*3 +: 3];
    end

    rr_priority_select #(.NUM_REQ(NUM_REQ)) u_rr (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant_oh   (win_oh),
        .grant_idx  (win_idx),
        .grant_any  (win_any)
    );

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_type_d    = op_type_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        fault_d      = fault_q;
        cnt_d        = cnt_q;
        req_ready    = '0;
        rsp_valid    = '0;
        eu_valid     = 1'b0;
        eu_ready_out = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                req_ready = win_oh;
                if (win_any) begin
                    op_a_d       = op_a_arr[win_idx];
                    op_b_d       = op_b_arr[win_idx];
                    op_type_d    = eltwise_op_e'(op_type_arr[win_idx]);
                    owner_d      = win_idx;
                    last_grant_d = win_idx;
                    cnt_d        = '0;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                eu_valid = 1'b1;
                if (timeout_hit) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    fault_d    = 1'b1;
                    state_d    = ST_RESPOND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (eu_ready) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                eu_ready_out = 1'b1;
                // A result arriving on the last allowed cycle still counts as completion.
                if (eu_valid_out) begin
                    rsp_data_d = eu_data;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_RESPOND;
                end else if (timeout_hit) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    fault_d    = 1'b1;
                    state_d    = ST_RESPOND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESPOND: begin
                rsp_valid[owner_q] = 1'b1;
                if (rsp_ready[owner_q]) begin
                    state_d = fault_q ? ST_HALT : ST_IDLE;
                end
            end
            ST_HALT: begin
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_type_q    <= OP_ADD;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            fault_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_type_q    <= op_type_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            fault_q      <= fault_d;
            cnt_q        <= cnt_d;
        end
    end

    assign eu_operand_a = op_a_q;
    assign eu_operand_b = op_b_q;
    assign eu_op_type   = op_type_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_err      = rsp_err_q;
    assign fault        = fault_q;
    assign busy         = (state_q != ST_IDLE);
    assign grant_id     = owner_q;

endmodule
